// File: rtl/filter_pad_feeder.sv
// Zero-padding stream source for the 3x3 line-buffer filter: wraps each image
// row in pad zero pixels and adds pad all-zero rows above and below the image.
module filter_pad_feeder #(
    parameter int img_width   = 320,
    parameter int img_height  = 240,
    parameter int kernel_size = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iValid,
    output logic        oReady,
    input  logic [23:0] iData,
    input  logic        iStall,
    output logic        oValid,
    output logic [23:0] oData,
    output logic        oSof,
    output logic        oDone
);

    localparam int PAD   = (kernel_size - 1) / 2;
    localparam int OUT_W = img_width + 2 * PAD;
    localparam int OUT_H = img_height + 2 * PAD;
    localparam int CW    = $clog2(OUT_W + 1);
    localparam int RW    = $clog2(OUT_H + 1);

    localparam logic [CW-1:0] C_LEFT  = CW'(PAD);
    localparam logic [CW-1:0] C_RIGHT = CW'(img_width + PAD);
    localparam logic [CW-1:0] C_LAST  = CW'(OUT_W - 1);
    localparam logic [RW-1:0] R_TOP   = RW'(PAD);
    localparam logic [RW-1:0] R_BOT   = RW'(img_height + PAD);
    localparam logic [RW-1:0] R_LAST  = RW'(OUT_H - 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_valid;
    logic [23:0]   r_data;
    logic          r_sof;
    logic          r_done;

    logic w_active;
    logic w_border;
    logic w_emit;
    logic w_colLast;
    logic w_lastPos;
    logic w_firstPos;

    assign w_active   = (r_state == S_ACTIVE);
    assign w_border   = (r_row < R_TOP) || (r_row >= R_BOT) ||
                        (r_col < C_LEFT) || (r_col >= C_RIGHT);
    // Border pixels are synthesised locally, so only interior ones wait on upstream.
    assign w_emit     = w_active && !iStall && (w_border || iValid);
    assign w_colLast  = (r_col == C_LAST);
    assign w_lastPos  = w_colLast && (r_row == R_LAST);
    assign w_firstPos = (r_col == '0) && (r_row == '0);

    assign oReady = w_active && !w_border && !iStall;
    assign oValid = r_valid;
    assign oData  = r_data;
    assign oSof   = r_sof;
    assign oDone  = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sof   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= w_emit;
            r_sof   <= w_emit && w_firstPos;
            r_done  <= w_emit && w_lastPos;
            if (w_emit) begin
                r_data <= w_border ? 24'h0 : iData;
            end

            case (r_state)
                S_IDLE: begin
                    r_col <= '0;
                    r_row <= '0;
                    if (iValid) begin
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (w_emit) begin
                        if (w_lastPos) begin
                            r_state <= S_IDLE;
                            r_col   <= '0;
                            r_row   <= '0;
                        end else if (w_colLast) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_pad_feeder.sv
// Self-checking bench for filter_pad_feeder on a 4x3 image: a cycle table for
// the start of a frame, then randomized traffic against a frame-level model.
module tb_filter_pad_feeder;

    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int KSZ   = 3;
    localparam int PAD   = (KSZ - 1) / 2;
    localparam int OUT_W = IMG_W + 2 * PAD;
    localparam int OUT_H = IMG_H + 2 * PAD;
    localparam int FRAME = OUT_W * OUT_H;

    logic        clk;
    logic        reset;
    logic        iValid;
    logic        oReady;
    logic [23:0] iData;
    logic        iStall;
    logic        oValid;
    logic [23:0] oData;
    logic        oSof;
    logic        oDone;

    filter_pad_feeder #(
        .img_width  (IMG_W),
        .img_height (IMG_H),
        .kernel_size(KSZ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .iValid(iValid),
        .oReady(oReady),
        .iData (iData),
        .iStall(iStall),
        .oValid(oValid),
        .oData (oData),
        .oSof  (oSof),
        .oDone (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        bit          s;
        bit          expReady;
        bit          expValid;
        logic [23:0] expData;
    } vec_t;

    vec_t        tbl[16];
    logic [23:0] srcq[$];
    logic [23:0] expq[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit active = 1'b0;
    int outIdx = 0;
    bit expValidNext = 1'b0;
    int frameHs = 0;
    int lastSofCyc = -1;
    int lastDoneCyc = -1;
    int prevDoneCyc = -1;
    int doneCount = 0;
    int expDoneCount = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    function automatic bit interior(input int idx);
        int r;
        int c;
        r = idx / OUT_W;
        c = idx % OUT_W;
        return (r >= PAD) && (r < IMG_H + PAD) && (c >= PAD) && (c < IMG_W + PAD);
    endfunction

    // Expected padded frame is built from raster rules, independent of any counters.
    task automatic loadFrame(input bit seq);
        logic [23:0] px;
        int n;
        n = 1;
        for (int idx = 0; idx < FRAME; idx++) begin
            if (interior(idx)) begin
                px = seq ? 24'(n) : 24'($urandom);
                n++;
                srcq.push_back(px);
                expq.push_back(px);
            end else begin
                expq.push_back(24'h0);
            end
        end
        expDoneCount++;
    endtask

    task automatic clearModel();
        srcq.delete();
        expq.delete();
        active = 1'b0;
        outIdx = 0;
        expValidNext = 1'b0;
        frameHs = 0;
        iValid = 1'b0;
        iStall = 1'b0;
    endtask

    // One clock: observe last edge's outputs, drive new inputs, check oReady before the edge.
    task automatic step(input bit v, input bit s);
        logic [23:0] want;
        bit          last;
        @(negedge clk);
        check("oValid", {31'h0, oValid}, {31'h0, expValidNext});
        if (oValid) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_output: got %0h expected no output at cycle %0d", oData, cyc);
            end else begin
                want = expq.pop_front();
                check("oData", {8'h0, oData}, {8'h0, want});
            end
            last = (outIdx == FRAME - 1);
            check("oSof", {31'h0, oSof}, {31'h0, outIdx == 0});
            check("oDone", {31'h0, oDone}, {31'h0, last});
            if (oSof) lastSofCyc = cyc;
            if (oDone) begin
                prevDoneCyc = lastDoneCyc;
                lastDoneCyc = cyc;
                doneCount++;
            end
            if (last) begin
                check("frame_handshakes", frameHs, IMG_W * IMG_H);
                outIdx = 0;
                active = 1'b0;
                frameHs = 0;
            end else begin
                outIdx++;
            end
        end else begin
            check("idle_flags", {30'h0, oSof, oDone}, 32'h0);
        end

        iValid = v && (srcq.size() > 0);
        iData  = (srcq.size() > 0) ? srcq[0] : 24'($urandom);
        iStall = s;
        #4;
        check("oReady", {31'h0, oReady}, {31'h0, active && interior(outIdx) && !s});
        expValidNext = active && !s && (!interior(outIdx) || iValid);
        if (iValid && oReady) begin
            void'(srcq.pop_front());
            frameHs++;
        end
        if (!active && iValid) active = 1'b1;
        cyc++;
    endtask

    task automatic runFrame(input int vPct, input int sPct, input int maxCyc);
        int n;
        n = 0;
        while (expq.size() > 0 && n < maxCyc) begin
            step(($urandom % 100) < vPct, ($urandom % 100) < sPct);
            n++;
        end
        check("frame_complete", expq.size(), 0);
        check("source_drained", srcq.size(), 0);
    endtask

    task automatic midReset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_oValid", {31'h0, oValid}, 32'h0);
        check("rst_oData", {8'h0, oData}, 32'h0);
        check("rst_oSof", {31'h0, oSof}, 32'h0);
        check("rst_oDone", {31'h0, oDone}, 32'h0);
        check("rst_oReady", {31'h0, oReady}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        clearModel();
    endtask

    initial begin
        int n;
        int c0;
        int d0;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 24'h0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 24'h1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 24'h2};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 24'h3};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h4};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h0};

        reset = 1'b1;
        iValid = 1'b0;
        iStall = 1'b0;
        iData = 24'h0;
        #3;
        check("reset_oValid", {31'h0, oValid}, 32'h0);
        check("reset_oData", {8'h0, oData}, 32'h0);
        check("reset_oSof", {31'h0, oSof}, 32'h0);
        check("reset_oDone", {31'h0, oDone}, 32'h0);
        check("reset_oReady", {31'h0, oReady}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        clearModel();

        // Cycle table for a frame start with one stall and one bubble, then finish that frame.
        loadFrame(1'b1);
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].s);
            check("tbl_oReady", {31'h0, oReady}, {31'h0, tbl[i].expReady});
            check("tbl_oValid", {31'h0, oValid}, {31'h0, tbl[i].expValid});
            if (tbl[i].expValid) check("tbl_oData", {8'h0, oData}, {8'h0, tbl[i].expData});
        end
        runFrame(100, 0, 200);

        // Basic gap-free frame: first output two cycles after iValid, 30 consecutive pixels.
        loadFrame(1'b1);
        c0 = cyc;
        runFrame(100, 0, 100);
        check("first_latency", lastSofCyc - c0, 2);
        check("frame_span", lastDoneCyc - lastSofCyc, FRAME - 1);

        // Upstream bubbles.
        loadFrame(1'b0);
        runFrame(50, 0, 400);

        // Five-cycle stall near row 2 col 3, then random stall and bubbles.
        loadFrame(1'b0);
        n = 0;
        while (outIdx < 2 * OUT_W + 3 && n < 60) begin
            step(1'b1, 1'b0);
            n++;
        end
        repeat (5) step(1'b1, 1'b1);
        runFrame(70, 40, 600);

        // Back-to-back frames with continuous supply.
        d0 = doneCount;
        loadFrame(1'b0);
        loadFrame(1'b0);
        runFrame(100, 0, 200);
        check("b2b_dones", doneCount - d0, 2);
        check("b2b_sof_gap", lastSofCyc - prevDoneCyc, 2);

        // Reset at output pixel 17, then a clean frame.
        loadFrame(1'b0);
        expDoneCount--;
        n = 0;
        while (outIdx < 17 && n < 60) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("reached_pixel17", outIdx, 17);
        midReset();
        loadFrame(1'b0);
        runFrame(80, 20, 500);

        repeat (3) begin
            loadFrame(1'b0);
            runFrame(60, 30, 800);
        end

        check("total_dones", doneCount, expDoneCount);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
